sha2_msg_sched: RTL and testbench

Parametrised SHA-2 message scheduler: accepts one 16-word padded message block and streams the round words W0..W(ROUNDS-1) to the compression core under a valid/yumi handshake. It is the next generation of the team's SHA-256 scheduler and adds three things: a word width that selects between the SHA-256 and SHA-512 sigma functions, a configurable round count, and proper input and output flow control. It sits between the block padder/loader and the round datapath.

---
 rtl/sha2_msg_sched_if.sv | 29 ++
 rtl/sha2_msg_sched.sv | 136 +++++++++++++
 tb/tb_sha2_msg_sched.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha2_msg_sched_if.sv
// Handshake bundle for sha2_msg_sched: block input (M_i/v_i/ready_o) and
// round-word output stream (Wt_o/t_o/v_o/yumi_i) plus status.
interface sha2_msg_sched_if #(
  parameter int unsigned WORD_W = 32
);
  localparam int unsigned BLOCK_W = 16 * WORD_W;

  logic [BLOCK_W-1:0] M_i;
  logic               v_i;
  logic               ready_o;
  logic [WORD_W-1:0]  Wt_o;
  logic [6:0]         t_o;
  logic               v_o;
  logic               yumi_i;
  logic               last_o;
  logic               busy_o;

  // Scheduler side.
  modport slave (
    input  M_i, v_i, yumi_i,
    output ready_o, Wt_o, t_o, v_o, last_o, busy_o
  );

  // Loader / compression-core side.
  modport master (
    output M_i, v_i, yumi_i,
    input  ready_o, Wt_o, t_o, v_o, last_o, busy_o
  );
endinterface

// File: rtl/sha2_msg_sched.sv
// SHA-2 message scheduler: loads a 16-word block and streams W0..W(ROUNDS-1)
// under a valid/yumi handshake. WORD_W selects SHA-256 (32) or SHA-512 (64)
// sigma functions. Optional macro SHA2_MSG_SCHED_PREFETCH_EN adds a one-block
// input buffer so consecutive blocks stream with no bubble.
module sha2_msg_sched #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned ROUNDS  = 64,
  parameter int unsigned BLOCK_W = 16 * WORD_W
) (
  input logic             clk_i,
  input logic             reset_i,
  sha2_msg_sched_if.slave bus_io
);

  if (WORD_W != 32 && WORD_W != 64) begin : gen_bad_word_w
    $error("sha2_msg_sched: WORD_W must be 32 or 64");
  end
  if (ROUNDS < 16 || ROUNDS > 127) begin : gen_bad_rounds
    $error("sha2_msg_sched: ROUNDS must be in 16..127");
  end
  if (BLOCK_W != 16 * WORD_W) begin : gen_bad_block_w
    $error("sha2_msg_sched: BLOCK_W is derived and must not be overridden");
  end

  localparam logic [6:0]  TLast = 7'(ROUNDS - 1);
  localparam int unsigned S0R1  = (WORD_W == 64) ? 1  : 7;
  localparam int unsigned S0R2  = (WORD_W == 64) ? 8  : 18;
  localparam int unsigned S0Sh  = (WORD_W == 64) ? 7  : 3;
  localparam int unsigned S1R1  = (WORD_W == 64) ? 19 : 17;
  localparam int unsigned S1R2  = (WORD_W == 64) ? 61 : 19;
  localparam int unsigned S1Sh  = (WORD_W == 64) ? 6  : 10;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q;
  logic [6:0]        t_q;
  logic              rdy_en_q;
  logic [WORD_W-1:0] win_q [16];
  logic [WORD_W-1:0] msg_w [16];
  logic [WORD_W-1:0] sig0, sig1, wnew;
  logic              xfer, at_last;
`ifdef SHA2_MSG_SCHED_PREFETCH_EN
  logic [WORD_W-1:0] buf_q [16];
  logic              buf_valid_q;
`endif

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // Split the incoming block into words, word 0 in the most significant slot.
  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      msg_w[i] = bus_io.M_i[BLOCK_W-1-i*WORD_W -: WORD_W];
    end
  end

  // Next schedule word from the current window.
  always_comb begin
    sig0 = rotr(win_q[1], S0R1) ^ rotr(win_q[1], S0R2) ^ (win_q[1] >> S0Sh);
    sig1 = rotr(win_q[14], S1R1) ^ rotr(win_q[14], S1R2) ^ (win_q[14] >> S1Sh);
    wnew = sig1 + win_q[9] + sig0 + win_q[0];
  end

  assign xfer    = bus_io.v_i & bus_io.ready_o;
  assign at_last = (state_q == StRun) && (t_q == TLast);

  // rdy_en_q keeps ready_o low during reset and until the first clock after it.
`ifdef SHA2_MSG_SCHED_PREFETCH_EN
  assign bus_io.ready_o = rdy_en_q & ~buf_valid_q;
`else
  assign bus_io.ready_o = rdy_en_q & (state_q == StIdle);
`endif

  assign bus_io.Wt_o   = win_q[0];
  assign bus_io.t_o    = t_q;
  assign bus_io.v_o    = (state_q == StRun);
  assign bus_io.busy_o = (state_q == StRun);
  assign bus_io.last_o = at_last;

  // Scheduler FSM, sliding window, round counter and optional prefetch buffer.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      t_q      <= '0;
      rdy_en_q <= 1'b0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
`ifdef SHA2_MSG_SCHED_PREFETCH_EN
      buf_valid_q <= 1'b0;
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
`endif
    end else begin
      rdy_en_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (xfer) begin
            win_q   <= msg_w;
            t_q     <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
`ifdef SHA2_MSG_SCHED_PREFETCH_EN
          // A transfer on the final yumi with an empty buffer bypasses it.
          if (xfer && !(bus_io.yumi_i && at_last)) begin
            buf_q       <= msg_w;
            buf_valid_q <= 1'b1;
          end
`endif
          if (bus_io.yumi_i) begin
            if (at_last) begin
              t_q <= '0;
`ifdef SHA2_MSG_SCHED_PREFETCH_EN
              if (buf_valid_q) begin
                win_q       <= buf_q;
                buf_valid_q <= 1'b0;
              end else if (xfer) begin
                win_q <= msg_w;
              end else begin
                state_q <= StIdle;
              end
`else
              state_q <= StIdle;
`endif
            end else begin
              for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
              win_q[15] <= wnew;
              t_q       <= t_q + 7'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha2_msg_sched.sv
// Bench for sha2_msg_sched: SHA-256 and SHA-512 instances checked against a
// flat W[t] recurrence model, with golden vectors, random flow control, reset
// mid-block and back-to-back block timing.
module tb_sha2_msg_sched;

`ifdef SHA2_MSG_SCHED_PREFETCH_EN
  localparam bit Prefetch = 1'b1;
`else
  localparam bit Prefetch = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sha2_msg_sched_if #(.WORD_W(32)) if32 ();
  sha2_msg_sched_if #(.WORD_W(64)) if64 ();

  sha2_msg_sched #(.WORD_W(32), .ROUNDS(64)) u_dut32 (
    .clk_i  (clk),
    .reset_i(reset),
    .bus_io (if32)
  );

  sha2_msg_sched #(.WORD_W(64), .ROUNDS(80)) u_dut64 (
    .clk_i  (clk),
    .reset_i(reset),
    .bus_io (if64)
  );

  typedef struct packed {
    logic        is64;
    logic [6:0]  t;
    logic [63:0] exp;
  } vec_t;

  int          n_pass;
  int          n_total;
  logic [63:0] mdl [128];
  logic [63:0] got [128];
  logic        cur_v, cur_last, cur_ready, cur_busy;
  logic [63:0] cur_w;
  logic [6:0]  cur_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] r32(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x};
    return d[n +: 32];
  endfunction

  function automatic logic [63:0] r64(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x};
    return d[n +: 64];
  endfunction

  function automatic logic [31:0] s0_32(input logic [31:0] x);
    return r32(x, 7) ^ r32(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1_32(input logic [31:0] x);
    return r32(x, 17) ^ r32(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [63:0] s0_64(input logic [63:0] x);
    return r64(x, 1) ^ r64(x, 8) ^ (x >> 7);
  endfunction
  function automatic logic [63:0] s1_64(input logic [63:0] x);
    return r64(x, 19) ^ r64(x, 61) ^ (x >> 6);
  endfunction

  // W[t] by the textbook recurrence over the whole schedule.
  task automatic build_model(input logic [1023:0] m, input bit is64);
    for (int i = 0; i < 16; i++) begin
      if (is64) mdl[i] = m[1023-64*i -: 64];
      else      mdl[i] = {32'd0, m[511-32*i -: 32]};
    end
    for (int t = 16; t < 128; t++) begin
      if (is64) mdl[t] = s1_64(mdl[t-2]) + mdl[t-7] + s0_64(mdl[t-15]) + mdl[t-16];
      else mdl[t] = {32'd0, s1_32(mdl[t-2][31:0]) + mdl[t-7][31:0]
                          + s0_32(mdl[t-15][31:0]) + mdl[t-16][31:0]};
    end
  endtask

  function automatic logic [1023:0] rand_blk();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input bit is64);
    if (is64) begin
      cur_v = if64.v_o; cur_w = if64.Wt_o; cur_t = if64.t_o;
      cur_last = if64.last_o; cur_ready = if64.ready_o; cur_busy = if64.busy_o;
    end else begin
      cur_v = if32.v_o; cur_w = {32'd0, if32.Wt_o}; cur_t = if32.t_o;
      cur_last = if32.last_o; cur_ready = if32.ready_o; cur_busy = if32.busy_o;
    end
  endtask

  task automatic drive(input bit is64, input logic v, input logic [1023:0] m, input logic y);
    if (is64) begin
      if64.v_i = v; if64.M_i = m; if64.yumi_i = y;
    end else begin
      if32.v_i = v; if32.M_i = m[511:0]; if32.yumi_i = y;
    end
  endtask

  // Offer one block, then consume it with yumi at yumi_pct percent. Returns early
  // (yumi low) when the stream reaches index stop_at.
  task automatic run_block(input bit is64, input logic [1023:0] m, input int yumi_pct,
                           input bit poke, input int stop_at);
    int   rounds;
    int   idx;
    int   cyc;
    logic y, vp;
    rounds = is64 ? 80 : 64;
    idx = 0;
    cyc = 0;
    build_model(m, is64);
    drive(is64, 1'b1, m, 1'b0);
    sample(is64);
    chk("ready_idle", 64'(cur_ready), 64'd1);
    tick();
    drive(is64, 1'b0, '0, 1'b0);
    while (idx < rounds && cyc < rounds * 10) begin
      sample(is64);
      chk("v_o", 64'(cur_v), 64'd1);
      chk("t_o", 64'(cur_t), 64'(idx));
      chk("Wt_o", cur_w, mdl[idx]);
      chk("last_o", 64'(cur_last), 64'(idx == rounds - 1));
      got[idx] = cur_w;
      if (idx == stop_at) return;
      y  = ($urandom_range(99) < 32'(yumi_pct));
      vp = poke && ($urandom_range(3) == 0);
      if (vp) chk("ready_run", 64'(cur_ready), 64'd0);
      drive(is64, vp, rand_blk(), y);
      tick();
      if (y) idx++;
      cyc++;
    end
    chk("block_done", 64'(idx), 64'(rounds));
    drive(is64, 1'b0, '0, 1'b0);
    sample(is64);
    chk("idle_v_o", 64'(cur_v), 64'd0);
    chk("idle_busy", 64'(cur_busy), 64'd0);
    chk("idle_ready", 64'(cur_ready), 64'd1);
  endtask

  // Consume the 32-bit stream with yumi=1 until v_o drops, comparing words.
  task automatic drain(output int nwords, output int nbad);
    nwords = 0;
    nbad = 0;
    for (int c = 0; c < 400; c++) begin
      sample(1'b0);
      if (!cur_v) break;
      if (cur_w !== mdl[cur_t]) nbad++;
      nwords++;
      drive(1'b0, 1'b0, '0, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1023:0] abc32, abc64, m2;
    vec_t vecs [9];
    int first, second, zeros, bad, nw, nb;
    logic rdy_after;

    abc32 = {512'd0, 32'h61626380, 448'd0, 32'h00000018};
    abc64 = {64'h6162638000000000, 896'd0, 64'h18};
    vecs[0] = '{1'b0, 7'd0,  64'h61626380};
    vecs[1] = '{1'b0, 7'd1,  64'h0};
    vecs[2] = '{1'b0, 7'd14, 64'h0};
    vecs[3] = '{1'b0, 7'd15, 64'h18};
    vecs[4] = '{1'b0, 7'd16, 64'h61626380};
    vecs[5] = '{1'b0, 7'd17, 64'h000F0000};
    vecs[6] = '{1'b1, 7'd0,  64'h6162638000000000};
    vecs[7] = '{1'b1, 7'd15, 64'h18};
    vecs[8] = '{1'b1, 7'd16, 64'h6162638000000000};

    n_pass = 0;
    n_total = 0;
    drive(1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    sample(1'b0);
    chk("rst_v_o", 64'(cur_v), 64'd0);
    chk("rst_ready", 64'(cur_ready), 64'd0);
    chk("rst_Wt_o", cur_w, 64'd0);
    chk("rst_t_o", 64'(cur_t), 64'd0);
    chk("rst_last", 64'(cur_last), 64'd0);
    chk("rst_busy", 64'(cur_busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    sample(1'b0);
    chk("ready_before_clk", 64'(cur_ready), 64'd0);
    tick();
    sample(1'b0);
    chk("ready_after_clk", 64'(cur_ready), 64'd1);

    // Golden "abc" blocks, yumi held high
    run_block(1'b0, abc32, 100, 1'b0, -1);
    for (int i = 0; i < 9; i++)
      if (!vecs[i].is64) chk($sformatf("abc32_W%0d", vecs[i].t), got[vecs[i].t], vecs[i].exp);
    run_block(1'b1, abc64, 100, 1'b0, -1);
    for (int i = 0; i < 9; i++)
      if (vecs[i].is64) chk($sformatf("abc64_W%0d", vecs[i].t), got[vecs[i].t], vecs[i].exp);

    // Random blocks, random yumi; v_i pokes during RUN when there is no buffer
    for (int k = 0; k < 3; k++) run_block(1'b0, rand_blk(), 50, !Prefetch, -1);
    run_block(1'b1, rand_blk(), 50, 1'b0, -1);

    // Reset asserted between edges at t_o=30
    run_block(1'b0, abc32, 100, 1'b0, 30);
    drive(1'b0, 1'b0, '0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    sample(1'b0);
    chk("midrst_v_o", 64'(cur_v), 64'd0);
    chk("midrst_Wt_o", cur_w, 64'd0);
    chk("midrst_t_o", 64'(cur_t), 64'd0);
    chk("midrst_ready", 64'(cur_ready), 64'd0);
    tick();
    @(negedge clk);
    reset = 1'b0;
    tick();
    run_block(1'b0, rand_blk(), 50, 1'b0, -1);

    // Back-to-back: v_i held, yumi whenever v_o
    build_model(abc32, 1'b0);
    first = -1;
    second = -1;
    zeros = 0;
    bad = 0;
    rdy_after = 1'b1;
    drive(1'b0, 1'b1, abc32, 1'b0);
    for (int c = 0; c < 300 && second < 0; c++) begin
      tick();
      sample(1'b0);
      if (first >= 0 && c == first + 1) rdy_after = cur_ready;
      if (cur_v) begin
        if (cur_w !== mdl[cur_t]) bad++;
        if (cur_t == 7'd0) begin
          if (first < 0) first = c;
          else second = c;
        end
      end else if (first >= 0) begin
        zeros++;
      end
      drive(1'b0, 1'b1, abc32, cur_v);
    end
    chk("b2b_period", 64'(second - first), Prefetch ? 64'd64 : 64'd65);
    chk("b2b_gap", 64'(zeros), Prefetch ? 64'd0 : 64'd1);
    chk("b2b_words", 64'(bad), 64'd0);
    chk("b2b_ready_full", 64'(rdy_after), 64'd0);
    drive(1'b0, 1'b0, '0, 1'b1);
    drain(nw, nb);
    chk("b2b_drain_words", 64'(nb), 64'd0);
    chk("b2b_drain_end", 64'(cur_v), 64'd0);

    // Offer arriving exactly on the final yumi
    m2 = rand_blk();
    build_model(abc32, 1'b0);
    drive(1'b0, 1'b1, abc32, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b1);
    for (int c = 0; c < 200; c++) begin
      sample(1'b0);
      if (cur_v && cur_t == 7'd63) break;
      tick();
    end
    chk("byp_t63", 64'(cur_t), 64'd63);
    drive(1'b0, 1'b1, m2, 1'b1);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0);
    sample(1'b0);
    if (Prefetch) begin
      chk("byp_v_o", 64'(cur_v), 64'd1);
      chk("byp_t_o", 64'(cur_t), 64'd0);
      chk("byp_ready", 64'(cur_ready), 64'd1);
      build_model(m2, 1'b0);
      drain(nw, nb);
      chk("byp_nwords", 64'(nw), 64'd64);
      chk("byp_words", 64'(nb), 64'd0);
    end else begin
      chk("final_offer_v_o", 64'(cur_v), 64'd0);
      chk("final_offer_busy", 64'(cur_busy), 64'd0);
      chk("final_offer_ready", 64'(cur_ready), 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
